// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection and IF/ID pipeline register.
// Define IF_STAGE_STALL_CNT_EN to add the saturating StallCount output.
module if_stage #(
  parameter int unsigned               PC_WIDTH    = 8,
  parameter int unsigned               INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]       RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]    NOP_INSTR   = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCWrite,
  input  logic                   IFIDWrite,
  input  logic                   PCSrc,
  input  logic                   Flush,
  input  logic [PC_WIDTH-1:0]    BranchTarget,
  output logic [PC_WIDTH-1:0]    ImemAddr,
  input  logic [INSTR_WIDTH-1:0] ImemData,
  output logic [INSTR_WIDTH-1:0] IFIDInstr,
  output logic [PC_WIDTH-1:0]    IFIDPCPlus1,
  output logic                   IFIDValid
`ifdef IF_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]            StallCount
`endif
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus1;

  // Natural modulo-2^PC_WIDTH wrap; no overflow indication.
  assign pc_plus1 = pc + PC_WIDTH'(1);
  assign ImemAddr = pc;

  // A redirect wins over a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (PCSrc) begin
      pc <= BranchTarget;
    end else if (PCWrite) begin
      pc <= pc_plus1;
    end
  end

  // A flush inserts a bubble even while the register is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IFIDInstr   <= NOP_INSTR;
      IFIDPCPlus1 <= '0;
      IFIDValid   <= 1'b0;
    end else if (Flush) begin
      IFIDInstr   <= NOP_INSTR;
      IFIDPCPlus1 <= '0;
      IFIDValid   <= 1'b0;
    end else if (IFIDWrite) begin
      IFIDInstr   <= ImemData;
      IFIDPCPlus1 <= pc_plus1;
      IFIDValid   <= 1'b1;
    end
  end

`ifdef IF_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (!PCWrite && !PCSrc && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; StallCount checks are active when IF_STAGE_STALL_CNT_EN is defined.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        PCSrc;
  logic        Flush;
  logic [7:0]  BranchTarget;
  logic [7:0]  ImemAddr;
  logic [15:0] ImemData;
  logic [15:0] IFIDInstr;
  logic [7:0]  IFIDPCPlus1;
  logic        IFIDValid;
`ifdef IF_STAGE_STALL_CNT_EN
  logic [15:0] StallCount;
`endif

  int unsigned n_vec;
  int unsigned n_err;

  if_stage #(
    .PC_WIDTH   (8),
    .INSTR_WIDTH(16),
    .RESET_PC   (8'h00),
    .NOP_INSTR  (16'h0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PCWrite     (PCWrite),
    .IFIDWrite   (IFIDWrite),
    .PCSrc       (PCSrc),
    .Flush       (Flush),
    .BranchTarget(BranchTarget),
    .ImemAddr    (ImemAddr),
    .ImemData    (ImemData),
    .IFIDInstr   (IFIDInstr),
    .IFIDPCPlus1 (IFIDPCPlus1),
    .IFIDValid   (IFIDValid)
`ifdef IF_STAGE_STALL_CNT_EN
    ,
    .StallCount  (StallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] instr,
                            input logic [7:0] pcp1, input logic valid);
    check({tag, ".instr"}, 32'(IFIDInstr), 32'(instr));
    check({tag, ".pcp1"},  32'(IFIDPCPlus1), 32'(pcp1));
    check({tag, ".valid"}, 32'(IFIDValid), 32'(valid));
  endtask

  initial begin
    logic [15:0] seq_data [3];
    seq_data[0] = 16'hA001;
    seq_data[1] = 16'hA002;
    seq_data[2] = 16'hA003;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    PCWrite = 1'b0; IFIDWrite = 1'b0; PCSrc = 1'b0; Flush = 1'b0;
    BranchTarget = 8'h00; ImemData = 16'h0000;

    step(); step();
    check("rst.addr", 32'(ImemAddr), 32'h00);
    check_ifid("rst", 16'h0000, 8'h00, 1'b0);
`ifdef IF_STAGE_STALL_CNT_EN
    check("rst.stall", 32'(StallCount), 32'h0);
`endif
    reset = 1'b0;

    // Sequential fetch
    PCWrite = 1'b1; IFIDWrite = 1'b1;
    check("seq.addr0", 32'(ImemAddr), 32'h00);
    for (int i = 0; i < 3; i++) begin
      ImemData = seq_data[i];
      step();
      check($sformatf("seq.addr%0d", i + 1), 32'(ImemAddr), 32'(i + 1));
      check_ifid($sformatf("seq%0d", i), seq_data[i], 8'(i + 1), 1'b1);
    end
    ImemData = 16'hA004; step();
    ImemData = 16'hA005; step();
    check("pre_stall.addr", 32'(ImemAddr), 32'h05);

    // Stall two cycles at PC=5
    PCWrite = 1'b0; IFIDWrite = 1'b0; ImemData = 16'hBEEF;
    step(); step();
    check("stall.addr", 32'(ImemAddr), 32'h05);
    check_ifid("stall", 16'hA005, 8'h05, 1'b1);
`ifdef IF_STAGE_STALL_CNT_EN
    check("stall.cnt", 32'(StallCount), 32'h2);
`endif

    // Redirect + flush while stalled
    PCSrc = 1'b1; BranchTarget = 8'h40; Flush = 1'b1;
    step();
    check("redir.addr", 32'(ImemAddr), 32'h40);
    check_ifid("redir", 16'h0000, 8'h00, 1'b0);
`ifdef IF_STAGE_STALL_CNT_EN
    check("redir.cnt", 32'(StallCount), 32'h2);
`endif

    // Wrap: jump to 0xFF, then advance
    Flush = 1'b0; BranchTarget = 8'hFF;
    step();
    check("wrap.pre", 32'(ImemAddr), 32'hFF);
    PCSrc = 1'b0; PCWrite = 1'b1; IFIDWrite = 1'b1; ImemData = 16'hC0FF;
    step();
    check("wrap.addr", 32'(ImemAddr), 32'h00);
    check_ifid("wrap", 16'hC0FF, 8'h00, 1'b1);

    // PC advances while IF/ID holds
    IFIDWrite = 1'b0; ImemData = 16'h1234;
    step();
    check("indep.addr", 32'(ImemAddr), 32'h01);
    check_ifid("indep", 16'hC0FF, 8'h00, 1'b1);

    // Asynchronous reset mid-cycle at PC=0x23, during a stall
    PCSrc = 1'b1; BranchTarget = 8'h23; IFIDWrite = 1'b1; ImemData = 16'h5555;
    step();
    check("pre_rst.addr", 32'(ImemAddr), 32'h23);
    check_ifid("pre_rst", 16'h5555, 8'h02, 1'b1);
    PCSrc = 1'b0; PCWrite = 1'b0; IFIDWrite = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst.addr", 32'(ImemAddr), 32'h00);
    check_ifid("arst", 16'h0000, 8'h00, 1'b0);
`ifdef IF_STAGE_STALL_CNT_EN
    check("arst.cnt", 32'(StallCount), 32'h0);
`endif
    step();
    reset = 1'b0;
    PCWrite = 1'b1; IFIDWrite = 1'b1; ImemData = 16'h7777;
    step();
    check("post_rst.addr", 32'(ImemAddr), 32'h01);
    check_ifid("post_rst", 16'h7777, 8'h01, 1'b1);

`ifdef IF_STAGE_STALL_CNT_EN
    // Saturation from a preloaded count
    PCWrite = 1'b0; IFIDWrite = 1'b0;
    force dut.stall_cnt = 16'hFFFE;
    #1 release dut.stall_cnt;
    step(); step(); step();
    check("sat.cnt", 32'(StallCount), 32'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
- REQ-001 SHALL have parameter PC_WIDTH, default 8: width of the PC and of all instruction addresses.
- REQ-002 SHALL have parameter INSTR_WIDTH, default 16: width of an instruction word.
- REQ-003 SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
- REQ-004 SHALL have parameter NOP_INSTR, default 0: instruction word inserted on reset and on flush.
- REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
- REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
- REQ-007 SHALL have port PCWrite, input, 1 bit: PC advance enable from the hazard unit; 0 = stall.
- REQ-008 SHALL have port IFIDWrite, input, 1 bit: IF/ID register load enable from the hazard unit; 0 = hold.
- REQ-009 SHALL have port PCSrc, input, 1 bit: 1 = redirect the PC to BranchTarget (taken branch or jump).
- REQ-010 SHALL have port Flush, input, 1 bit: 1 = squash the IF/ID register contents.
- REQ-011 SHALL have port BranchTarget, input, PC_WIDTH bits: redirect address.
- REQ-012 SHALL have port ImemAddr, output, PC_WIDTH bits: instruction memory address.
- REQ-013 SHALL have port ImemData, input, INSTR_WIDTH bits: instruction memory read data, combinational from ImemAddr.
- REQ-014 SHALL have port IFIDInstr, output, INSTR_WIDTH bits: registered instruction presented to decode.
- REQ-015 SHALL have port IFIDPCPlus1, output, PC_WIDTH bits: registered address of the next sequential instruction.
- REQ-016 SHALL have port IFIDValid, output, 1 bit: 1 = IFIDInstr is a real fetched instruction; 0 = bubble.

Function
- REQ-017 SHALL drive ImemAddr combinationally equal to the PC register (zero-latency fetch).
- REQ-018 SHALL update the PC per cycle with priority: PCSrc=1 -> BranchTarget; else PCWrite=1 -> PC+1; else hold.
- REQ-019 SHALL apply redirect even when PCWrite=0; PCSrc overrides a stall.
- REQ-020 SHALL compute PC+1 modulo 2^PC_WIDTH; PC all-ones wraps to 0 with no error flag.
- REQ-021 SHALL update the IF/ID register per cycle with priority: Flush=1 -> IFIDInstr=NOP_INSTR, IFIDPCPlus1=0, IFIDValid=0; else IFIDWrite=1 -> IFIDInstr=ImemData, IFIDPCPlus1=PC+1, IFIDValid=1; else hold all three.
- REQ-022 SHALL let Flush override IFIDWrite=0: a flush during a stall still inserts a bubble.
- REQ-023 SHALL give a one-cycle latency from fetch address to IFIDInstr.
- REQ-024 SHALL treat PCWrite and IFIDWrite independently; no internal consistency check between them.

Reset
- REQ-025 SHALL, while reset=1 and regardless of clk, force PC=RESET_PC, IFIDInstr=NOP_INSTR, IFIDPCPlus1=0, IFIDValid=0, and the stall counter (when present) to 0.
- REQ-026 SHALL fetch from RESET_PC on the first rising edge after reset deasserts; a reset asserted mid-stall or mid-redirect discards that operation.

Configuration
- REQ-027 SHALL, when macro IF_STAGE_STALL_CNT_EN is defined, add output StallCount (16 bits): it increments on each rising edge with PCWrite=0 and PCSrc=0, saturates at 16'hFFFF, and is unaffected by Flush.
- REQ-028 SHALL, when IF_STAGE_STALL_CNT_EN is undefined, omit the StallCount port and its counter entirely, with all other behaviour identical.

Verification
- REQ-029 SHALL check reset: assert reset asynchronously mid-cycle with PC=0x23 -> ImemAddr=0x00, IFIDValid=0, and IFIDInstr=NOP_INSTR immediately, without waiting for a clock edge.
- REQ-030 SHALL check sequential fetch: PCWrite=IFIDWrite=1 for 3 cycles with ImemData=0xA001, 0xA002, 0xA003 -> ImemAddr steps 0, 1, 2, 3, and IFIDInstr/IFIDPCPlus1 follow as (0xA001, 1), (0xA002, 2), (0xA003, 3).
- REQ-031 SHALL check stall: PC=5 with PCWrite=IFIDWrite=0 for 2 cycles -> PC stays 5, IF/ID outputs hold, and StallCount rises by 2 (macro defined).
- REQ-032 SHALL check redirect during a stall: PCWrite=0, PCSrc=1, BranchTarget=0x40, Flush=1 -> next cycle ImemAddr=0x40, IFIDValid=0, IFIDInstr=NOP_INSTR, and StallCount unchanged.
- REQ-033 SHALL check wrap: PC=0xFF with PCWrite=1 -> PC=0x00 and IFIDPCPlus1=0x00.
- REQ-034 SHALL check saturation: with StallCount preloaded to 0xFFFE by 3 stall cycles via force -> count ends at 0xFFFF; with the macro undefined, the bench compiles without the StallCount port.
